// File: rtl/cache_instructions_set_assoc_if.sv
// Bundles the fetch-side request/response signals and the BurstRAM command/read
// channel of the set-associative instruction cache.
// slave  = the cache itself; master = the fetch stage plus the RAM controller.
interface cache_instructions_set_assoc_if #(
   parameter int ADDRESS_BITWIDTH        = 32,
   parameter int DATA_BITWIDTH           = 32,
   parameter int RAM_BURST_DATA_BITWIDTH = 64,
   parameter int RAM_DEPTH_BITWIDTH      = 8
);
   logic                                 enable;
   logic [ADDRESS_BITWIDTH-1:0]          address;
   logic                                 invalidate;
   logic [DATA_BITWIDTH-1:0]             data;
   logic                                 data_ready;
   logic                                 busy;
   logic [31:0]                          stat_hits;
   logic [31:0]                          stat_misses;
   logic                                 br_cmd;
   logic                                 br_cmd_en;
   logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr;
   logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data;
   logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask;
   logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data;
   logic                                 br_rd_data_valid;
   logic                                 br_busy;

   modport slave (
      input  enable, address, invalidate, br_rd_data, br_rd_data_valid, br_busy,
      output data, data_ready, busy, stat_hits, stat_misses,
             br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );

   modport master (
      output enable, address, invalidate, br_rd_data, br_rd_data_valid, br_busy,
      input  data, data_ready, busy, stat_hits, stat_misses,
             br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask
   );
endinterface

// File: rtl/cache_instructions_set_assoc.sv
// N-way set-associative instruction cache between the fetch stage and the
// BurstRAM controller. A miss refills a whole line with one burst read, the
// requested word is forwarded as soon as its beat lands, and replacement is
// lowest-invalid-way first, otherwise a per-set round-robin pointer.
module cache_instructions_set_assoc #(
   parameter int ADDRESS_BITWIDTH               = 32,
   parameter int DATA_BITWIDTH                  = 32,
   parameter int DATA_IX_IN_LINE_BITWIDTH       = 3,
   parameter int SET_IX_BITWIDTH                = 1,
   parameter int WAYS_BITWIDTH                  = 1,
   parameter int ADDRESS_LEADING_ZEROS_BITWIDTH = 2,
   parameter int RAM_BURST_DATA_COUNT           = 4,
   parameter int RAM_BURST_DATA_BITWIDTH        = 64,
   parameter int RAM_DEPTH_BITWIDTH             = 8
) (
   input logic clk,
   input logic rst,
   cache_instructions_set_assoc_if.slave bus
);
   localparam int TAG_W  = ADDRESS_BITWIDTH - SET_IX_BITWIDTH - DATA_IX_IN_LINE_BITWIDTH
                           - ADDRESS_LEADING_ZEROS_BITWIDTH;
   localparam int SETS   = 1 << SET_IX_BITWIDTH;
   localparam int WAYS   = 1 << WAYS_BITWIDTH;
   localparam int WORDS  = 1 << DATA_IX_IN_LINE_BITWIDTH;
   localparam int WPB    = RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH;
   localparam int WPB_W  = $clog2(WPB);
   localparam int BEAT_W = DATA_IX_IN_LINE_BITWIDTH - WPB_W;
   localparam int SLOT_W = SET_IX_BITWIDTH + WAYS_BITWIDTH;
   localparam int LINE_W = TAG_W + SET_IX_BITWIDTH + BEAT_W;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RECV  = 2'd3;

   // request address fields
   logic [TAG_W-1:0]                          req_tag;
   logic [SET_IX_BITWIDTH-1:0]                req_set;
   logic [DATA_IX_IN_LINE_BITWIDTH-1:0]       req_word;
   logic [ADDRESS_LEADING_ZEROS_BITWIDTH-1:0] unused_zeros;

   assign {req_tag, req_set, req_word, unused_zeros} = bus.address;

   // control state
   logic [1:0]                          state;
   logic [TAG_W-1:0]                    cur_tag;
   logic [SET_IX_BITWIDTH-1:0]          cur_set;
   logic [DATA_IX_IN_LINE_BITWIDTH-1:0] cur_word;
   logic [WAYS_BITWIDTH-1:0]            cur_way;
   logic                                cur_by_rr;
   logic [BEAT_W-1:0]                   beat_cnt;
   logic                                inv_pend;
   logic [SETS*WAYS-1:0]                valid;
   logic [WAYS_BITWIDTH-1:0]            rr [SETS];

   // storage, indexed {set, way, word} and {set, way}
   logic [DATA_BITWIDTH-1:0] lines [SETS*WAYS*WORDS];
   logic [TAG_W-1:0]         tags  [SETS*WAYS];

   logic                     hit;
   logic [WAYS_BITWIDTH-1:0] hit_way;
   logic [WAYS_BITWIDTH-1:0] victim;
   logic                     victim_by_rr;
   logic [DATA_BITWIDTH-1:0] beat_word;
   logic                     beat_valid;
   logic                     last_beat;
   logic [LINE_W-1:0]        line_beat;
   logic [LINE_W-RAM_DEPTH_BITWIDTH-1:0] unused_line_hi;

   assign beat_valid = bus.br_rd_data_valid && (state == WAIT || state == RECV);
   assign last_beat  = beat_valid && (beat_cnt == BEAT_W'(RAM_BURST_DATA_COUNT - 1));
   // RAM addresses count beats, so the line base drops the word-in-beat and zero bits
   assign line_beat  = {cur_tag, cur_set, {BEAT_W{1'b0}}};
   assign unused_line_hi = line_beat[LINE_W-1:RAM_DEPTH_BITWIDTH];

   assign bus.br_cmd       = 1'b0;
   assign bus.br_wr_data   = '0;
   assign bus.br_data_mask = '0;

   // tag compare across all ways of the addressed set
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hit && valid[{req_set, WAYS_BITWIDTH'(w)}] &&
             tags[{req_set, WAYS_BITWIDTH'(w)}] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAYS_BITWIDTH'(w);
         end
      end
   end

   // victim choice: lowest invalid way, else the set's round-robin pointer
   always_comb begin
      victim       = rr[req_set];
      victim_by_rr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[{req_set, WAYS_BITWIDTH'(w)}]) begin
            victim       = WAYS_BITWIDTH'(w);
            victim_by_rr = 1'b0;
         end
      end
   end

   // pick the requested word out of the incoming beat for early forwarding
   always_comb begin
      beat_word = '0;
      for (int j = 0; j < WPB; j++) begin
         if (WPB_W'(j) == cur_word[WPB_W-1:0]) begin
            beat_word = bus.br_rd_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
         end
      end
   end

   // line data and tag writes during refill
   always_ff @(posedge clk) begin
      if (beat_valid) begin
         for (int j = 0; j < WPB; j++) begin
            lines[{cur_set, cur_way, beat_cnt, WPB_W'(j)}] <=
               bus.br_rd_data[j*DATA_BITWIDTH +: DATA_BITWIDTH];
         end
      end
      if (last_beat) begin
         tags[{cur_set, cur_way}] <= cur_tag;
      end
   end

   // fetch FSM, valid bits, replacement pointers, RAM command and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         cur_tag         <= '0;
         cur_set         <= '0;
         cur_word        <= '0;
         cur_way         <= '0;
         cur_by_rr       <= 1'b0;
         beat_cnt        <= '0;
         inv_pend        <= 1'b0;
         valid           <= '0;
         for (int s = 0; s < SETS; s++) rr[s] <= '0;
         bus.data        <= '0;
         bus.data_ready  <= 1'b0;
         bus.busy        <= 1'b0;
         bus.br_cmd_en   <= 1'b0;
         bus.br_addr     <= '0;
         bus.stat_hits   <= '0;
         bus.stat_misses <= '0;
      end else begin
         bus.data_ready <= 1'b0;
         bus.br_cmd_en  <= 1'b0;
         // an invalidate that arrives mid-miss is remembered until the line is done
         if (state != IDLE && bus.invalidate) inv_pend <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.invalidate || inv_pend) begin
                  valid    <= '0;
                  inv_pend <= 1'b0;
               end else if (bus.enable) begin
                  if (hit) begin
                     bus.data       <= lines[{req_set, hit_way, req_word}];
                     bus.data_ready <= 1'b1;
                     bus.stat_hits  <= bus.stat_hits + 32'd1;
                  end else begin
                     bus.stat_misses <= bus.stat_misses + 32'd1;
                     bus.busy        <= 1'b1;
                     state           <= ISSUE;
                     cur_tag         <= req_tag;
                     cur_set         <= req_set;
                     cur_word        <= req_word;
                     cur_way         <= victim;
                     cur_by_rr       <= victim_by_rr;
                     beat_cnt        <= '0;
                     valid[{req_set, victim}] <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               if (!bus.br_busy) begin
                  bus.br_cmd_en <= 1'b1;
                  bus.br_addr   <= line_beat[RAM_DEPTH_BITWIDTH-1:0];
                  state         <= WAIT;
               end
            end
            WAIT, RECV: begin
               if (bus.br_rd_data_valid) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  state    <= RECV;
                  if (beat_cnt == cur_word[DATA_IX_IN_LINE_BITWIDTH-1:WPB_W]) begin
                     bus.data       <= beat_word;
                     bus.data_ready <= 1'b1;
                  end
                  if (last_beat) begin
                     valid[{cur_set, cur_way}] <= 1'b1;
                     if (cur_by_rr) rr[cur_set] <= rr[cur_set] + 1'b1;
                     beat_cnt <= '0;
                     bus.busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_instructions_set_assoc.sv
// Directed bench for cache_instructions_set_assoc: a burst-RAM responder, a
// transaction-level cache model (hit/miss, victim choice, counters) and a
// per-cycle compare of forwarded words and RAM commands against that model.
`timescale 1ns/1ps
module tb_cache_instructions_set_assoc;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cache_instructions_set_assoc_if bus ();
   cache_instructions_set_assoc dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s", name);
   endtask

   // RAM content: any word address maps to a distinct recognisable value;
   // line 0 holds 0x00000000, 0x11111111, ... 0x77777777
   function automatic logic [31:0] ramword(input int unsigned a);
      logic [31:0] lo, hi;
      lo = 32'(a & 7) * 32'h11111111;
      hi = 32'(a >> 3) << 28;
      return lo + hi;
   endfunction

   function automatic logic [63:0] beat_of(input int unsigned b);
      return {ramword(2*b + 1), ramword(2*b)};
   endfunction

   // ---------------- cache model ----------------
   bit          m_valid [2][2];
   logic [31:0] m_tag   [2][2];
   int          m_rr    [2];
   int          m_hits  = 0;
   int          m_misses = 0;
   logic [31:0] exp_words [$];
   logic [7:0]  exp_addrs [$];

   task automatic model_req(input logic [31:0] a, output bit hit);
      int s, v;
      logic [31:0] t;
      s = int'((a >> 5) & 1);
      t = a >> 6;
      hit = 1'b0;
      for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hit = 1'b1;
      exp_words.push_back(ramword(a >> 2));
      if (hit) m_hits++;
      else begin
         m_misses++;
         v = -1;
         for (int w = 0; w < 2; w++) if (!m_valid[s][w] && v < 0) v = w;
         if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % 2;
         end
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = t;
         exp_addrs.push_back(8'((a & ~32'd31) >> 3));
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < 2; s++) for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
   endtask

   task automatic model_reset();
      model_clear();
      for (int s = 0; s < 2; s++) m_rr[s] = 0;
      m_hits = 0;
      m_misses = 0;
      exp_words.delete();
      exp_addrs.delete();
   endtask

   // ---------------- burst RAM responder ----------------
   int lat = 2;
   int gap = 0;
   int beats_sent = 0;
   int last_beat_cycle = 0;
   bit resp_busy = 1'b0;

   initial begin
      int unsigned b;
      bus.br_rd_data_valid = 1'b0;
      bus.br_rd_data = '0;
      forever begin
         @(negedge clk);
         if (bus.br_cmd_en && !rst) begin
            b = bus.br_addr;
            resp_busy = 1'b1;
            beats_sent = 0;
            for (int k = 0; k < 4; k++) begin
               repeat (k == 0 ? lat : gap) begin
                  bus.br_rd_data_valid = 1'b0;
                  @(negedge clk);
               end
               bus.br_rd_data_valid = 1'b1;
               bus.br_rd_data = beat_of(b + k);
               beats_sent = k + 1;
               if (k == 3) last_beat_cycle = cyc;
               @(negedge clk);
            end
            bus.br_rd_data_valid = 1'b0;
            resp_busy = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int cmd_pulses = 0;
   logic [7:0] last_cmd_addr = '0;

   always @(negedge clk) begin
      if (!rst) begin
         check("br_cmd", bus.br_cmd, 1'b0);
         if (bus.data_ready) begin
            if (exp_words.size() == 0) fail_now("unexpected_data_ready");
            else check("data", bus.data, exp_words.pop_front());
         end
         if (bus.br_cmd_en) begin
            cmd_pulses++;
            last_cmd_addr = bus.br_addr;
            if (exp_addrs.size() == 0) fail_now("unexpected_br_cmd_en");
            else check("br_addr", bus.br_addr, exp_addrs.pop_front());
         end
      end
   end

   // ---------------- fetch driver ----------------
   task automatic fetch(input logic [31:0] a, input int hold, input int inv_beats,
                        output bit obs_hit, output logic [31:0] got);
      bit mhit, crit_seen, inv_done;
      int n;
      n = 0;
      while (bus.busy && n < 300) begin @(negedge clk); n++; end
      if (bus.busy) fail_now("idle_timeout");
      model_req(a, mhit);
      bus.address = a;
      bus.enable  = 1'b1;
      if (hold > 0) bus.br_busy = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      obs_hit = !bus.busy;
      got = bus.data;
      check("hit_vs_model", obs_hit, mhit);
      check("stat_hits", bus.stat_hits, m_hits);
      check("stat_misses", bus.stat_misses, m_misses);
      if (obs_hit) check("hit_ready", bus.data_ready, 1'b1);
      else begin
         for (int i = 0; i < hold; i++) begin
            check("cmd_held", bus.br_cmd_en, 1'b0);
            @(negedge clk);
         end
         bus.br_busy = 1'b0;
         crit_seen = 1'b0;
         inv_done  = 1'b0;
         n = 0;
         while (bus.busy && n < 300) begin
            if (bus.data_ready && !crit_seen) begin crit_seen = 1'b1; got = bus.data; end
            if (inv_beats >= 0 && !inv_done && resp_busy && beats_sent >= inv_beats) begin
               bus.invalidate = 1'b1;
               inv_done = 1'b1;
               model_clear();
            end else bus.invalidate = 1'b0;
            @(negedge clk);
            n++;
         end
         bus.invalidate = 1'b0;
         if (bus.data_ready && !crit_seen) begin crit_seen = 1'b1; got = bus.data; end
         if (bus.busy) fail_now("refill_timeout");
         else begin
            check("busy_drop_cycle", cyc, last_beat_cycle + 1);
            check("crit_forwarded", crit_seen, 1'b1);
         end
         if (inv_done) begin
            @(negedge clk);
            check("inv_no_ready", bus.data_ready, 1'b0);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, bus.data, 0);
      check({tag, "_data_ready"}, bus.data_ready, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_br_cmd"}, bus.br_cmd, 0);
      check({tag, "_br_cmd_en"}, bus.br_cmd_en, 0);
      check({tag, "_br_addr"}, bus.br_addr, 0);
      check({tag, "_stat_hits"}, bus.stat_hits, 0);
      check({tag, "_stat_misses"}, bus.stat_misses, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      bit h, mh;
      logic [31:0] d;
      int p0, n;
      bus.enable = 1'b0;
      bus.address = '0;
      bus.invalidate = 1'b0;
      bus.br_busy = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // cold miss, critical word in beat 0
      p0 = cmd_pulses;
      fetch(32'h004, 0, -1, h, d);
      check("cold_is_miss", h, 1'b0);
      check("cold_crit_word", d, 32'h11111111);
      check("cold_cmd_pulses", cmd_pulses - p0, 1);
      check("cold_br_addr", last_cmd_addr, 8'h00);
      check("cold_misses", bus.stat_misses, 1);

      // hit in the refilled line
      fetch(32'h01C, 0, -1, h, d);
      check("hit_flag", h, 1'b1);
      check("hit_word", d, 32'h77777777);
      check("hit_count", bus.stat_hits, 1);

      // round-robin eviction in set 0
      fetch(32'h040, 0, -1, h, d);
      check("fill040_miss", h, 1'b0);
      check("fill040_addr", last_cmd_addr, 8'h08);
      fetch(32'h080, 0, -1, h, d);
      check("fill080_miss", h, 1'b0);
      check("fill080_addr", last_cmd_addr, 8'h10);
      fetch(32'h040, 0, -1, h, d);
      check("still040_hit", h, 1'b1);
      fetch(32'h008, 0, -1, h, d);
      check("evicted000_miss", h, 1'b0);
      check("evicted000_word", d, 32'h22222222);

      // br_busy held for 5 cycles
      p0 = cmd_pulses;
      fetch(32'h020, 5, -1, h, d);
      check("hold_miss", h, 1'b0);
      check("hold_cmd_pulses", cmd_pulses - p0, 1);
      check("hold_br_addr", last_cmd_addr, 8'h04);

      // stalled burst, critical word in the last beat
      gap = 2;
      fetch(32'h0B8, 0, -1, h, d);
      gap = 0;
      check("stall_miss", h, 1'b0);
      check("stall_crit_word", d, 32'hB6666666);

      // back-to-back hits, one per cycle
      model_req(32'h024, mh);
      bus.address = 32'h024;
      bus.enable = 1'b1;
      @(negedge clk);
      check("b2b_first_ready", bus.data_ready, 1'b1);
      check("b2b_first_busy", bus.busy, 1'b0);
      check("b2b_first_word", bus.data, 32'h21111111);
      check("b2b_first_hits", bus.stat_hits, m_hits);
      model_req(32'h0BC, mh);
      bus.address = 32'h0BC;
      @(negedge clk);
      bus.enable = 1'b0;
      check("b2b_second_ready", bus.data_ready, 1'b1);
      check("b2b_second_word", bus.data, 32'hC7777777);
      check("b2b_second_hits", bus.stat_hits, m_hits);

      // invalidate in IDLE wins over a simultaneous enable
      p0 = bus.stat_hits;
      bus.address = 32'h01C;
      bus.enable = 1'b1;
      bus.invalidate = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      bus.invalidate = 1'b0;
      model_clear();
      check("inv_idle_ready", bus.data_ready, 1'b0);
      check("inv_idle_busy", bus.busy, 1'b0);
      check("inv_idle_hits", bus.stat_hits, p0);

      // invalidate pulsed mid-refill clears the freshly filled line too
      gap = 1;
      fetch(32'h008, 0, 2, h, d);
      gap = 0;
      check("inv_refill_miss", h, 1'b0);
      check("inv_refill_word", d, 32'h22222222);
      fetch(32'h000, 0, -1, h, d);
      check("after_inv_miss", h, 1'b0);

      // asynchronous reset in the middle of a burst
      gap = 2;
      model_req(32'h040, mh);
      bus.address = 32'h040;
      bus.enable = 1'b1;
      @(negedge clk);
      bus.enable = 1'b0;
      check("rst_req_miss", bus.busy, 1'b1);
      n = 0;
      while (!(resp_busy && beats_sent >= 2) && n < 300) begin @(negedge clk); n++; end
      if (n >= 300) fail_now("rst_beats_timeout");
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      #1 check_all_zero("midreset");
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      while (resp_busy && n < 300) begin
         check("leftover_ready", bus.data_ready, 1'b0);
         check("leftover_busy", bus.busy, 1'b0);
         @(negedge clk);
         n++;
      end
      if (resp_busy) fail_now("leftover_timeout");
      gap = 0;
      fetch(32'h01C, 0, -1, h, d);
      check("post_rst_miss", h, 1'b0);
      check("post_rst_word", d, 32'h77777777);
      fetch(32'h004, 0, -1, h, d);
      check("post_rst_hit", h, 1'b1);
      check("post_rst_hit_word", d, 32'h11111111);
      check("post_rst_hits", bus.stat_hits, 1);
      check("post_rst_misses", bus.stat_misses, 1);

      repeat (3) @(negedge clk);
      check("pending_words", exp_words.size(), 0);
      check("pending_cmds", exp_addrs.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
